// File: rtl/axi_pkg.sv
// axi_pkg: AXI4-Lite manager/subordinate channel bundles.
package axi_pkg;
    typedef struct packed {
        logic                         awvalid;
        logic [top_pkg::AXI_AW-1:0]   awaddr;
        logic [2:0]                   awprot;
        logic                         wvalid;
        logic [top_pkg::AXI_DW-1:0]   wdata;
        logic [top_pkg::AXI_DBW-1:0]  wstrb;
        logic                         bready;
        logic                         arvalid;
        logic [top_pkg::AXI_AW-1:0]   araddr;
        logic [2:0]                   arprot;
        logic                         rready;
    } axi_h2d_t;

    typedef struct packed {
        logic                         awready;
        logic                         wready;
        logic                         bvalid;
        logic [1:0]                   bresp;
        logic                         arready;
        logic                         rvalid;
        logic [top_pkg::AXI_DW-1:0]   rdata;
        logic [1:0]                   rresp;
    } axi_d2h_t;
endpackage

// File: rtl/top_pkg.sv
// top_pkg: bus and AXI width constants shared across the SoC.
package top_pkg;
    localparam int AXI_AW  = 32;
    localparam int AXI_DW  = 32;
    localparam int AXI_DBW = AXI_DW / 8;
endpackage

// File: rtl/axi_host_adapter.sv
// axi_host_adapter: req/gnt/valid device port to AXI4-Lite manager, up to
// MAX_REQS outstanding transactions answered in request order.
module axi_host_adapter #(
    parameter int MAX_REQS = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_i,
    output logic                          gnt_o,
    input  logic                          we_i,
    input  logic [top_pkg::AXI_DBW-1:0]   be_i,
    input  logic [top_pkg::AXI_AW-1:0]    addr_i,
    input  logic [top_pkg::AXI_DW-1:0]    wdata_i,
    output logic                          valid_o,
    output logic [top_pkg::AXI_DW-1:0]    rdata_o,
    output logic                          err_o,
    output axi_pkg::axi_h2d_t             axi_o,
    input  axi_pkg::axi_d2h_t             axi_i
);
    localparam int CW = $clog2(MAX_REQS + 1);

    logic                         iss_valid_q, iss_valid_d;
    logic                         we_q, we_d;
    logic [top_pkg::AXI_AW-1:0]   addr_q, addr_d;
    logic [top_pkg::AXI_DBW-1:0]  be_q, be_d;
    logic [top_pkg::AXI_DW-1:0]   wdata_q, wdata_d;
    logic                         aw_done_q, aw_done_d;
    logic                         w_done_q, w_done_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [MAX_REQS-1:0]          ord_q, ord_d;
    logic                         valid_q, valid_d;
    logic                         err_q, err_d;
    logic [top_pkg::AXI_DW-1:0]   rdata_q, rdata_d;

    logic awvalid, wvalid, arvalid, bready, rready;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, pop, iss_done;
    logic [CW-1:0] cnt_eff;
    logic unused_resp;

    // Valids come from flops only, so none depends on a ready.
    assign awvalid  = iss_valid_q & we_q & ~aw_done_q;
    assign wvalid   = iss_valid_q & we_q & ~w_done_q;
    assign arvalid  = iss_valid_q & ~we_q;
    // The order FIFO occupancy equals the outstanding count; ord_q[0] is its head.
    assign bready   = (cnt_q != '0) & ord_q[0];
    assign rready   = (cnt_q != '0) & ~ord_q[0];
    assign aw_hs    = awvalid & axi_i.awready;
    assign w_hs     = wvalid & axi_i.wready;
    assign ar_hs    = arvalid & axi_i.arready;
    assign b_hs     = bready & axi_i.bvalid;
    assign r_hs     = rready & axi_i.rvalid;
    assign pop      = b_hs | r_hs;
    assign cnt_eff  = cnt_q - CW'(pop);
    assign iss_done = we_q ? ((aw_done_q | aw_hs) & (w_done_q | w_hs)) : ar_hs;
    assign gnt_o    = req_i & ~iss_valid_q & (cnt_eff < CW'(MAX_REQS));
    assign unused_resp = axi_i.bresp[0] ^ axi_i.rresp[0];

    always_comb begin
        iss_valid_d = (iss_valid_q & ~iss_done) | gnt_o;
        we_d        = gnt_o ? we_i : we_q;
        addr_d      = gnt_o ? addr_i : addr_q;
        be_d        = gnt_o ? be_i : be_q;
        wdata_d     = gnt_o ? wdata_i : wdata_q;
        aw_done_d   = ~gnt_o & (aw_done_q | aw_hs);
        w_done_d    = ~gnt_o & (w_done_q | w_hs);
        cnt_d       = cnt_eff + CW'(gnt_o);
        ord_d       = pop ? ord_q >> 1 : ord_q;
        for (int i = 0; i < MAX_REQS; i++)
            if (gnt_o && cnt_eff == CW'(i)) ord_d[i] = we_i;
        valid_d     = pop;
        err_d       = b_hs ? axi_i.bresp[1] : r_hs ? axi_i.rresp[1] : err_q;
        rdata_d     = b_hs ? '0 : r_hs ? axi_i.rdata : rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cnt_q       <= '0;
            ord_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cnt_q       <= cnt_d;
            ord_q       <= ord_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        axi_o         = '0;
        axi_o.awvalid = awvalid;
        axi_o.awaddr  = addr_q;
        axi_o.wvalid  = wvalid;
        axi_o.wdata   = wdata_q;
        axi_o.wstrb   = be_q;
        axi_o.bready  = bready;
        axi_o.arvalid = arvalid;
        axi_o.araddr  = addr_q;
        axi_o.rready  = rready;
    end

    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
endmodule

// File: tb/tb_axi_host_adapter.sv
// tb_axi_host_adapter: vector table plus corner-case sequences against a
// reactive AXI-Lite subordinate, responses checked through a scoreboard.
module tb_axi_host_adapter;
    import axi_pkg::*;

    logic clk = 1'b0, rst_ni = 1'b0, req_i = 1'b0, we_i = 1'b0;
    logic [3:0] be_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic gnt_o, valid_o, err_o;
    logic [31:0] rdata_o;
    axi_h2d_t axi_o;
    axi_d2h_t axi_i;

    axi_host_adapter #(.MAX_REQS(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
        .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .valid_o(valid_o),
        .rdata_o(rdata_o), .err_o(err_o), .axi_o(axi_o), .axi_i(axi_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdata_unused;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          aw_dly, w_dly, ar_dly;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int total = 0, bad = 0, cyc = 0, vcount = 0, last_vcyc = 0;
    exp_t sb[$];
    exp_t me;
    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Subordinate: readies after a programmable wait, responses queued in order.
    int aw_dly = 0, w_dly = 0, ar_dly = 0, aw_cnt, w_cnt, ar_cnt;
    bit hold_b = 0, hold_r = 0;
    bit aw_p, w_p, ar_p, b_p, r_p, aw_got, w_got;
    logic [1:0] bq[$];
    logic [33:0] rq[$];
    logic [31:0] aw_a, ar_a, awaddr_s;

    function automatic logic [31:0] sub_rdata(input logic [31:0] a);
        return a == 32'h40000 ? 32'hDEADBEEF : ~a;
    endfunction
    function automatic logic [1:0] sub_rresp(input logic [31:0] a);
        return a[30] ? 2'b11 : a[29] ? 2'b01 : 2'b00;
    endfunction

    always @(negedge clk) begin
        if (!rst_ni) begin
            axi_i = '0;
            bq.delete();
            rq.delete();
            {aw_p, w_p, ar_p, b_p, r_p, aw_got, w_got} = '0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        end else begin
            if (b_p) bq.delete(0);
            if (r_p) rq.delete(0);
            if (ar_p) rq.push_back({sub_rdata(ar_a), sub_rresp(ar_a)});
            if (aw_p) begin aw_got = 1; awaddr_s = aw_a; end
            if (w_p) w_got = 1;
            if (aw_got && w_got) begin
                bq.push_back(awaddr_s[31] ? 2'b10 : 2'b00);
                aw_got = 0; w_got = 0;
            end
            axi_i.awready = axi_o.awvalid && aw_cnt >= aw_dly;
            aw_cnt = (axi_o.awvalid && !axi_i.awready) ? aw_cnt + 1 : 0;
            axi_i.wready = axi_o.wvalid && w_cnt >= w_dly;
            w_cnt = (axi_o.wvalid && !axi_i.wready) ? w_cnt + 1 : 0;
            axi_i.arready = axi_o.arvalid && ar_cnt >= ar_dly;
            ar_cnt = (axi_o.arvalid && !axi_i.arready) ? ar_cnt + 1 : 0;
            axi_i.bvalid = bq.size() != 0 && !hold_b;
            axi_i.bresp = bq.size() != 0 ? bq[0] : 2'b00;
            axi_i.rvalid = rq.size() != 0 && !hold_r;
            {axi_i.rdata, axi_i.rresp} = rq.size() != 0 ? rq[0] : 34'h0;
            aw_p = axi_o.awvalid && axi_i.awready; aw_a = axi_o.awaddr;
            w_p  = axi_o.wvalid && axi_i.wready;
            ar_p = axi_o.arvalid && axi_i.arready; ar_a = axi_o.araddr;
            b_p  = axi_i.bvalid && axi_o.bready;
            r_p  = axi_i.rvalid && axi_o.rready;
        end
    end

    always @(negedge clk) begin
        if (rst_ni && valid_o) begin
            vcount++;
            last_vcyc = cyc;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected valid_o: got rdata %0h err %0b want no response", rdata_o, err_o);
            end else begin
                me = sb.pop_front();
                chk("resp rdata", rdata_o, me.rdata);
                chk("resp err", err_o, me.err);
            end
        end
    end

    task automatic start_req(input logic w, input logic [31:0] a, input logic [3:0] b,
                             input logic [31:0] d, input logic [31:0] er, input logic ee,
                             output int waits, output int gcyc);
        req_i = 1; we_i = w; addr_i = a; be_i = b; wdata_i = d;
        waits = 0;
        #1;
        while (!gnt_o && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        chk("grant", gnt_o, 1);
        if (gnt_o) sb.push_back('{rdata_unused: 1'b0, rdata: er, err: ee});
        gcyc = cyc;
        @(posedge clk); #1;
        req_i = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, g, v0;
        vecs[0] = '{0, 32'h0004_0000, 4'hF, 32'h0,         0, 0, 0, 32'hDEADBEEF, 1'b0, 3};
        vecs[1] = '{1, 32'h0000_1000, 4'h3, 32'h1234_5678, 0, 0, 0, 32'h0,        1'b0, 3};
        vecs[2] = '{1, 32'h8000_0010, 4'hF, 32'hCAFE_F00D, 0, 0, 0, 32'h0,        1'b1, 3};
        vecs[3] = '{0, 32'h4000_0020, 4'hF, 32'h0,         0, 0, 0, 32'hBFFF_FFDF, 1'b1, 3};
        vecs[4] = '{0, 32'h2000_0004, 4'hF, 32'h0,         0, 0, 2, 32'hDFFF_FFFB, 1'b0, 5};
        vecs[5] = '{1, 32'h0000_0100, 4'h8, 32'hA5A5_A5A5, 1, 2, 0, 32'h0,        1'b0, 5};
        vecs[6] = '{0, 32'h0000_0008, 4'hF, 32'h0,         0, 0, 0, 32'hFFFF_FFF7, 1'b0, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("rst valid_o", valid_o, 0);
        chk("rst err/rdata", {err_o, rdata_o}, 0);
        chk("rst axi valids/readies", {axi_o.awvalid, axi_o.wvalid, axi_o.arvalid, axi_o.bready, axi_o.rready}, 0);
        chk("rst gnt idle", gnt_o, 0);
        rst_ni = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            aw_dly = vecs[i].aw_dly; w_dly = vecs[i].w_dly; ar_dly = vecs[i].ar_dly;
            start_req(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                      vecs[i].exp_rdata, vecs[i].exp_err, w, g);
            if (vecs[i].we) begin
                chk($sformatf("v%0d aw/w/ar valid", i), {axi_o.awvalid, axi_o.wvalid, axi_o.arvalid}, 3'b110);
                chk($sformatf("v%0d awaddr", i), axi_o.awaddr, vecs[i].addr);
                chk($sformatf("v%0d wdata/wstrb", i), {axi_o.wdata, axi_o.wstrb}, {vecs[i].wdata, vecs[i].be});
                chk($sformatf("v%0d awprot", i), axi_o.awprot, 0);
            end else begin
                chk($sformatf("v%0d aw/w/ar valid", i), {axi_o.awvalid, axi_o.wvalid, axi_o.arvalid}, 3'b001);
                chk($sformatf("v%0d araddr", i), axi_o.araddr, vecs[i].addr);
                chk($sformatf("v%0d arprot", i), axi_o.arprot, 0);
            end
            drain();
            chk($sformatf("v%0d latency", i), last_vcyc - g, vecs[i].exp_lat);
        end

        // AW held off three cycles while W completes at once.
        aw_dly = 3; w_dly = 0; ar_dly = 0;
        start_req(1, 32'h600, 4'b0101, 32'h0BAD_F00D, 32'h0, 1'b0, w, g);
        for (int k = 1; k <= 4; k++) begin
            chk("split awvalid held", axi_o.awvalid, 1);
            chk("split wvalid", axi_o.wvalid, k == 1);
            req_i = 1; we_i = 0; addr_i = 32'h44;
            #1;
            chk("split no early grant", gnt_o, 0);
            req_i = 0;
            @(posedge clk); #1;
        end
        chk("split awvalid dropped", axi_o.awvalid, 0);
        start_req(0, 32'h44, 4'hF, 32'h0, ~32'h44, 1'b0, w, g);
        chk("split regrant immediate", w, 0);
        aw_dly = 0;
        drain();

        // Two reads outstanding with responses withheld; third waits for the pop.
        hold_r = 1;
        start_req(0, 32'h10, 4'hF, 32'h0, ~32'h10, 1'b0, w, g);
        start_req(0, 32'h14, 4'hF, 32'h0, ~32'h14, 1'b0, w, g);
        req_i = 1; we_i = 0; addr_i = 32'h18;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("limit no grant", gnt_o, 0);
            @(posedge clk); #1;
        end
        hold_r = 0;
        @(negedge clk); #1;
        chk("limit grant on pop", {gnt_o, axi_i.rvalid, axi_o.rready}, 3'b111);
        if (gnt_o) sb.push_back('{rdata_unused: 1'b0, rdata: ~32'h18, err: 1'b0});
        @(posedge clk); #1;
        req_i = 0;
        drain();

        // Read response offered before the older write's B.
        hold_b = 1;
        start_req(1, 32'h200, 4'hC, 32'h55AA_55AA, 32'h0, 1'b0, w, g);
        start_req(0, 32'h300, 4'hF, 32'h0, ~32'h300, 1'b0, w, g);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("order rvalid/rready/bready", {axi_i.rvalid, axi_o.rready, axi_o.bready}, 3'b101);
            @(posedge clk); #1;
        end
        hold_b = 0;
        drain();

        // Reset with two transactions in flight.
        hold_b = 1; hold_r = 1;
        start_req(1, 32'h400, 4'hF, 32'h1, 32'h0, 1'b0, w, g);
        start_req(0, 32'h500, 4'hF, 32'h0, ~32'h500, 1'b0, w, g);
        @(posedge clk); #1;
        chk("pre-reset outstanding", {axi_o.bready, axi_o.rready}, 2'b10);
        rst_ni = 0;
        #1;
        chk("reset valid_o", valid_o, 0);
        chk("reset err/rdata", {err_o, rdata_o}, 0);
        chk("reset axi valids/readies", {axi_o.awvalid, axi_o.wvalid, axi_o.arvalid, axi_o.bready, axi_o.rready}, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_ni = 1; hold_b = 0; hold_r = 0;
        v0 = vcount;
        repeat (10) @(posedge clk);
        #1;
        chk("no valid after reset", vcount - v0, 0);
        start_req(0, 32'h0004_0000, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, w, g);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
